// File: rtl/sipo_word_receiver.sv
// MSB-first serial-to-parallel word receiver with frame resync, a single-entry
// valid/ready output buffer and sticky overrun / sync error flags.
module sipo_word_receiver #(
  parameter int unsigned WIDTH = 4,
  localparam int unsigned CW = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             serial_in,
  input  logic             bit_valid,
  input  logic             frame_start,
  input  logic             word_ready,
  input  logic             clear_err,
  output logic [WIDTH-1:0] word_out,
  output logic             word_valid,
  output logic [CW-1:0]    bit_count,
  output logic             busy,
  output logic             overrun,
  output logic             sync_err
);

  typedef enum logic [0:0] {StIdle, StRecv} state_e;
  typedef logic [WIDTH-2:0] sr_t;

  state_e          state_q;
  sr_t             sr_q;  // bits collected so far; only WIDTH-1 are ever pending
  logic [CW-1:0]   cnt_q;
  logic [WIDTH-1:0] word_q;
  logic            word_valid_q;
  logic            overrun_q;
  logic            sync_err_q;

  logic             in_recv;
  logic             resync;
  logic             last_bit;
  logic             complete;
  logic [WIDTH-1:0] next_word;

  always_comb begin
    in_recv   = (state_q == StRecv);
    resync    = bit_valid && frame_start && in_recv;
    last_bit  = (cnt_q == CW'(WIDTH - 1));
    complete  = bit_valid && !frame_start && in_recv && last_bit;
    next_word = {sr_q, serial_in};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      sr_q         <= '0;
      cnt_q        <= '0;
      word_q       <= '0;
      word_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
      sync_err_q   <= 1'b0;
    end else begin
      // Receiver: sampling never stalls on output backpressure.
      if (bit_valid) begin
        if (frame_start) begin
          state_q <= StRecv;
          sr_q    <= sr_t'(serial_in);
          cnt_q   <= CW'(1);
        end else if (in_recv) begin
          sr_q <= next_word[WIDTH-2:0];
          if (last_bit) begin
            state_q <= StIdle;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
      end

      // Output buffer; a same-cycle consume frees the slot for the new word.
      if (complete) begin
        if (!word_valid_q || word_ready) begin
          word_q       <= next_word;
          word_valid_q <= 1'b1;
        end
      end else if (word_valid_q && word_ready) begin
        word_valid_q <= 1'b0;
      end

      // Clear first so a coinciding set condition wins.
      if (clear_err) begin
        overrun_q  <= 1'b0;
        sync_err_q <= 1'b0;
      end
      if (complete && word_valid_q && !word_ready) begin
        overrun_q <= 1'b1;
      end
      if (resync) begin
        sync_err_q <= 1'b1;
      end
    end
  end

  assign word_out   = word_q;
  assign word_valid = word_valid_q;
  assign bit_count  = cnt_q;
  assign busy       = in_recv;
  assign overrun    = overrun_q;
  assign sync_err   = sync_err_q;

endmodule

// File: tb/tb_sipo_word_receiver.sv
// Bench for sipo_word_receiver: directed scenarios plus random traffic, all
// checked against a queue-based model of the receive and buffer rules.
module tb_sipo_word_receiver;

  localparam int unsigned W  = 4;
  localparam int unsigned CW = $clog2(W + 1);

  logic          clk;
  logic          rst;
  logic          serial_in;
  logic          bit_valid;
  logic          frame_start;
  logic          word_ready;
  logic          clear_err;
  logic [W-1:0]  word_out;
  logic          word_valid;
  logic [CW-1:0] bit_count;
  logic          busy;
  logic          overrun;
  logic          sync_err;

  int n_checks = 0;
  int n_errors = 0;

  sipo_word_receiver #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .serial_in  (serial_in),
    .bit_valid  (bit_valid),
    .frame_start(frame_start),
    .word_ready (word_ready),
    .clear_err  (clear_err),
    .word_out   (word_out),
    .word_valid (word_valid),
    .bit_count  (bit_count),
    .busy       (busy),
    .overrun    (overrun),
    .sync_err   (sync_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: pending bits of the current frame, plus output state.
  bit           m_bits[$];
  logic [W-1:0] m_word;
  bit           m_valid;
  bit           m_ovr;
  bit           m_serr;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge(input bit s, input bit bv, input bit fs, input bit rdy,
                            input bit clr, input bit r);
    bit           done;
    logic [W-1:0] w;
    bit           was_valid;
    if (r) begin
      m_bits.delete();
      m_word  = '0;
      m_valid = 0;
      m_ovr   = 0;
      m_serr  = 0;
      return;
    end
    done      = 0;
    w         = '0;
    was_valid = m_valid;
    if (clr) begin
      m_ovr  = 0;
      m_serr = 0;
    end
    if (bv) begin
      if (fs) begin
        if (m_bits.size() != 0) m_serr = 1;
        m_bits.delete();
        m_bits.push_back(s);
      end else if (m_bits.size() != 0) begin
        m_bits.push_back(s);
        if (m_bits.size() == W) begin
          done = 1;
          for (int i = 0; i < W; i++) w = (w << 1) | W'(m_bits[i]);
          m_bits.delete();
        end
      end
    end
    if (done) begin
      if (!was_valid || rdy) begin
        m_word  = w;
        m_valid = 1;
      end else begin
        m_ovr = 1;
      end
    end else if (was_valid && rdy) begin
      m_valid = 0;
    end
  endtask

  task automatic compare_all();
    check_eq("word_out",   32'(word_out),   32'(m_word));
    check_eq("word_valid", 32'(word_valid), 32'(m_valid));
    check_eq("bit_count",  32'(bit_count),  32'(m_bits.size()));
    check_eq("busy",       32'(busy),       32'(m_bits.size() != 0));
    check_eq("overrun",    32'(overrun),    32'(m_ovr));
    check_eq("sync_err",   32'(sync_err),   32'(m_serr));
  endtask

  task automatic step(input bit s, input bit bv, input bit fs, input bit rdy,
                      input bit clr, input bit r);
    serial_in   = s;
    bit_valid   = bv;
    frame_start = fs;
    word_ready  = rdy;
    clear_err   = clr;
    rst         = r;
    @(posedge clk);
    model_edge(s, bv, fs, rdy, clr, r);
    #1;
    compare_all();
  endtask

  task automatic idle(input bit rdy);
    step(1'b0, 1'b0, 1'b0, rdy, 1'b0, 1'b0);
  endtask

  task automatic send_word(input logic [W-1:0] w, input bit rdy_last);
    for (int i = W - 1; i >= 0; i--) begin
      step(w[i], 1'b1, i == W - 1, (i == 0) ? rdy_last : 1'b0, 1'b0, 1'b0);
    end
  endtask

  logic [3:0] piso;
  logic [5:0] rs_bits;

  initial begin
    serial_in = 0; bit_valid = 0; frame_start = 0;
    word_ready = 0; clear_err = 0; rst = 1;

    // Reset state
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    check_eq("rst_word_valid", 32'(word_valid), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);

    // Basic word 1,0,1,1
    send_word(4'hB, 1'b0);
    check_eq("basic_word", 32'(word_out), 32'hB);
    check_eq("basic_valid", 32'(word_valid), 32'd1);
    check_eq("basic_count", 32'(bit_count), 32'd0);
    check_eq("basic_ovr", 32'(overrun), 32'd0);
    idle(1'b1);
    check_eq("consume_valid", 32'(word_valid), 32'd0);

    // Gapped bits: count holds across gaps
    for (int i = W - 1; i >= 0; i--) begin
      step(bit'((4'hB >> i) & 1), 1'b1, i == W - 1, 1'b0, 1'b0, 1'b0);
      for (int g = 0; g < 3; g++) begin
        idle(1'b0);
        if (i > 0) check_eq("gap_count", 32'(bit_count), 32'(W - i));
      end
    end
    check_eq("gap_word", 32'(word_out), 32'hB);
    idle(1'b1);

    // Overrun: B then 6 with no consume
    send_word(4'hB, 1'b0);
    send_word(4'h6, 1'b0);
    check_eq("ovr_word", 32'(word_out), 32'hB);
    check_eq("ovr_flag", 32'(overrun), 32'd1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check_eq("ovr_clear", 32'(overrun), 32'd0);
    // Same-cycle consume on completion
    send_word(4'h6, 1'b1);
    check_eq("cons_word", 32'(word_out), 32'h6);
    check_eq("cons_valid", 32'(word_valid), 32'd1);
    check_eq("cons_ovr", 32'(overrun), 32'd0);
    idle(1'b1);

    // Resync: 1,0 | 1,1,0,0
    rs_bits = 6'b10_1100;
    for (int i = 5; i >= 0; i--) begin
      step(rs_bits[i], 1'b1, (i == 5) || (i == 3), 1'b0, 1'b0, 1'b0);
    end
    check_eq("resync_err", 32'(sync_err), 32'd1);
    check_eq("resync_word", 32'(word_out), 32'hC);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    check_eq("serr_clear", 32'(sync_err), 32'd0);

    // Reset mid-word
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check_eq("midrst_busy", 32'(busy), 32'd0);
    check_eq("midrst_count", 32'(bit_count), 32'd0);
    check_eq("midrst_valid", 32'(word_valid), 32'd0);
    send_word(4'h7, 1'b0);
    check_eq("after_rst_word", 32'(word_out), 32'h7);
    idle(1'b1);

    // Upstream PISO loaded with A, shifted MSB-first for 4 cycles
    piso = 4'hA;
    for (int i = 0; i < 4; i++) begin
      step(piso[3], 1'b1, i == 0, 1'b0, 1'b0, 1'b0);
      piso = piso << 1;
    end
    check_eq("piso_word", 32'(word_out), 32'hA);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      step(bit'($urandom_range(1)), $urandom_range(99) < 60, $urandom_range(99) < 15,
           $urandom_range(99) < 35, $urandom_range(99) < 5, $urandom_range(999) < 8);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
